// File: rtl/rpc_dram_cmd_receiver.sv
// RPC DRAM command receiver: samples two-word command frames, decodes them,
// tracks per-bank open state and tRCD, and reports protocol errors.
module rpc_dram_cmd_receiver #(
    parameter int NUM_BANKS   = 4,
    parameter int ROW_WIDTH   = 13,
    parameter int TRCD_CYCLES = 4,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         rpc_cs_ni,
    input  logic                         rpc_stb_i,
    input  logic [15:0]                  rpc_db_i,
    output logic                         cmd_valid_o,
    input  logic                         cmd_ready_i,
    output logic [3:0]                   cmd_op_o,
    output logic [$clog2(NUM_BANKS)-1:0] cmd_bank_o,
    output logic [ROW_WIDTH-1:0]         cmd_row_o,
    output logic [9:0]                   cmd_col_o,
    output logic [5:0]                   cmd_blen_o,
    output logic [NUM_BANKS-1:0]         bank_open_o,
    output logic                         busy_o,
    output logic [5:0]                   err_o,
    input  logic                         err_clr_i
);
    // state  | meaning
    // S_IDLE | waiting for cs_n low together with stb
    // S_W0   | capturing command bits [15:0]
    // S_W1   | capturing command bits [31:16]; command handed to decode
    // S_DATA | ignoring blen+1 data beats of a RD/WR
    typedef enum logic [1:0] {S_IDLE, S_W0, S_W1, S_DATA} state_t;

    localparam int BANK_W = $clog2(NUM_BANKS);

    localparam logic [3:0] OP_ACT  = 4'd1;
    localparam logic [3:0] OP_RD   = 4'd2;
    localparam logic [3:0] OP_WR   = 4'd3;
    localparam logic [3:0] OP_PRE  = 4'd4;
    localparam logic [3:0] OP_PREA = 4'd5;
    localparam logic [3:0] OP_REF  = 4'd6;
    localparam logic [3:0] OP_ZQC  = 4'd7;
    localparam logic [3:0] OP_MRS  = 4'd8;

    localparam logic [CNT_WIDTH-1:0] TRCD_LOAD = CNT_WIDTH'(TRCD_CYCLES - 1);

    state_t      state, state_nxt;
    logic [31:0] cmd_q, cmd_nxt;
    logic [5:0]  beat_q, beat_nxt;
    logic        dec_q, dec_nxt;
    logic        abort;
    logic        stb_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= S_IDLE;
            cmd_q  <= '0;
            beat_q <= '0;
            dec_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cmd_q  <= cmd_nxt;
            beat_q <= beat_nxt;
            dec_q  <= dec_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_nxt   = cmd_q;
        beat_nxt  = beat_q;
        dec_nxt   = 1'b0;
        abort     = 1'b0;
        stb_err   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!rpc_cs_ni && rpc_stb_i) state_nxt = S_W0;
            end
            S_W0: begin
                if (rpc_cs_ni) begin
                    abort     = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    stb_err   = rpc_stb_i;
                    cmd_nxt   = {cmd_q[31:16], rpc_db_i};
                    state_nxt = S_W1;
                end
            end
            S_W1: begin
                if (rpc_cs_ni) begin
                    abort     = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    stb_err = rpc_stb_i;
                    cmd_nxt = {rpc_db_i, cmd_q[15:0]};
                    dec_nxt = 1'b1;
                    // op was captured in W0, blen arrives in this word
                    if (cmd_q[3:0] == OP_RD || cmd_q[3:0] == OP_WR) begin
                        beat_nxt  = rpc_db_i[15:10];
                        state_nxt = S_DATA;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (rpc_cs_ni) begin
                    abort     = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    stb_err = rpc_stb_i;
                    if (beat_q == '0) state_nxt = S_IDLE;
                    else beat_nxt = beat_q - 6'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy_o = (state != S_IDLE);

    logic [3:0]           dec_op;
    logic [BANK_W-1:0]    dec_bank;
    logic                 dec_act;
    logic                 dec_rdwr;

    assign dec_op   = cmd_q[3:0];
    assign dec_bank = cmd_q[4 +: BANK_W];
    assign dec_act  = (dec_op == OP_ACT);
    assign dec_rdwr = (dec_op == OP_RD) || (dec_op == OP_WR);

    logic [NUM_BANKS-1:0] open_nxt;
    logic [CNT_WIDTH-1:0] trcd_q   [NUM_BANKS];
    logic [CNT_WIDTH-1:0] trcd_nxt [NUM_BANKS];
    logic                 err_illegal;
    logic                 err_closed;
    logic                 err_act_open;
    logic                 err_trcd;
    logic                 collision;
    logic [5:0]           err_set;

    always_comb begin
        open_nxt     = bank_open_o;
        err_illegal  = 1'b0;
        err_closed   = 1'b0;
        err_act_open = 1'b0;
        err_trcd     = 1'b0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            trcd_nxt[i] = (trcd_q[i] == '0) ? '0 : trcd_q[i] - CNT_WIDTH'(1);
        end
        if (dec_q) begin
            case (dec_op)
                OP_ACT: begin
                    err_act_open       = bank_open_o[dec_bank];
                    open_nxt[dec_bank] = 1'b1;
                    trcd_nxt[dec_bank] = TRCD_LOAD;
                end
                OP_RD, OP_WR: begin
                    err_closed = ~bank_open_o[dec_bank];
                    err_trcd   = (trcd_q[dec_bank] != '0);
                end
                OP_PRE:           open_nxt[dec_bank] = 1'b0;
                OP_PREA:          open_nxt = '0;
                OP_REF, OP_ZQC:   err_closed = |bank_open_o;
                OP_MRS:           ;
                default:          err_illegal = 1'b1;
            endcase
        end
    end

    // a new decode while the previous command is still unaccepted overwrites it
    assign collision = dec_q & cmd_valid_o & ~cmd_ready_i;
    assign err_set   = {collision | stb_err, err_trcd, err_act_open,
                        err_closed, err_illegal, abort};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmd_valid_o <= 1'b0;
            cmd_op_o    <= '0;
            cmd_bank_o  <= '0;
            cmd_row_o   <= '0;
            cmd_col_o   <= '0;
            cmd_blen_o  <= '0;
            bank_open_o <= '0;
            err_o       <= '0;
            for (int i = 0; i < NUM_BANKS; i++) trcd_q[i] <= '0;
        end else begin
            bank_open_o <= open_nxt;
            for (int i = 0; i < NUM_BANKS; i++) trcd_q[i] <= trcd_nxt[i];
            err_o <= (err_clr_i ? 6'd0 : err_o) | err_set;
            if (dec_q) begin
                cmd_valid_o <= 1'b1;
                cmd_op_o    <= dec_op;
                cmd_bank_o  <= dec_bank;
                cmd_row_o   <= dec_act  ? cmd_q[6 +: ROW_WIDTH] : '0;
                cmd_col_o   <= dec_rdwr ? cmd_q[25:16] : '0;
                cmd_blen_o  <= dec_rdwr ? cmd_q[31:26] : '0;
            end else if (cmd_valid_o && cmd_ready_i) begin
                cmd_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rpc_dram_cmd_receiver.sv
// Bench for rpc_dram_cmd_receiver: frame-level reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_rpc_dram_cmd_receiver;
    localparam int NB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs_n = 1'b1;
    logic        stb = 1'b0;
    logic [15:0] db = '0;
    logic        ready = 1'b1;
    logic        err_clr = 1'b0;

    logic        dut_valid;
    logic [3:0]  dut_op;
    logic [1:0]  dut_bank;
    logic [12:0] dut_row;
    logic [9:0]  dut_col;
    logic [5:0]  dut_blen;
    logic [3:0]  dut_open;
    logic        dut_busy;
    logic [5:0]  dut_err;

    rpc_dram_cmd_receiver dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .rpc_cs_ni   (cs_n),
        .rpc_stb_i   (stb),
        .rpc_db_i    (db),
        .cmd_valid_o (dut_valid),
        .cmd_ready_i (ready),
        .cmd_op_o    (dut_op),
        .cmd_bank_o  (dut_bank),
        .cmd_row_o   (dut_row),
        .cmd_col_o   (dut_col),
        .cmd_blen_o  (dut_blen),
        .bank_open_o (dut_open),
        .busy_o      (dut_busy),
        .err_o       (dut_err),
        .err_clr_i   (err_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: a frame is stb followed by k = 1, 2, ... cycles; words at
    // k=1,2; the frame lasts 2 cycles, or 3+blen for RD/WR. The decoded command
    // appears on the outputs one edge after the second word.
    logic        m_valid;
    logic [3:0]  m_op;
    logic [1:0]  m_bank;
    logic [12:0] m_row;
    logic [9:0]  m_col;
    logic [5:0]  m_blen;
    logic [3:0]  m_open;
    logic [5:0]  m_err;
    int          m_trcd [NB];
    bit          in_frame;
    int          k;
    int          flen;
    logic [15:0] lo;
    bit          pend;
    logic [31:0] pend_cmd;

    task automatic model_step();
        logic [5:0] set;
        int         old_trcd [NB];
        logic [3:0] op;
        int         b;
        bit         next_pend;
        if (rst) begin
            m_valid = 0; m_op = 0; m_bank = 0; m_row = 0; m_col = 0; m_blen = 0;
            m_open = 0; m_err = 0; in_frame = 0; k = 0; flen = 0; lo = 0;
            pend = 0; pend_cmd = 0;
            for (int i = 0; i < NB; i++) m_trcd[i] = 0;
            return;
        end
        set = '0;
        for (int i = 0; i < NB; i++) begin
            old_trcd[i] = m_trcd[i];
            m_trcd[i]   = (m_trcd[i] > 0) ? m_trcd[i] - 1 : 0;
        end
        if (pend) begin
            op = pend_cmd[3:0];
            b  = int'(pend_cmd[5:4]);
            if (m_valid && !ready) set[5] = 1'b1;
            m_valid = 1'b1;
            m_op    = op;
            m_bank  = pend_cmd[5:4];
            m_row   = (op == 1) ? pend_cmd[18:6] : 13'd0;
            m_col   = (op == 2 || op == 3) ? pend_cmd[25:16] : 10'd0;
            m_blen  = (op == 2 || op == 3) ? pend_cmd[31:26] : 6'd0;
            case (op)
                4'd1: begin
                    if (m_open[b]) set[3] = 1'b1;
                    m_open[b] = 1'b1;
                    m_trcd[b] = 3;
                end
                4'd2, 4'd3: begin
                    if (!m_open[b]) set[2] = 1'b1;
                    if (old_trcd[b] != 0) set[4] = 1'b1;
                end
                4'd4: m_open[b] = 1'b0;
                4'd5: m_open = 4'b0000;
                4'd6, 4'd7: if (m_open != 0) set[2] = 1'b1;
                4'd8: ;
                default: set[1] = 1'b1;
            endcase
        end else if (m_valid && ready) begin
            m_valid = 1'b0;
        end
        next_pend = 0;
        if (!in_frame) begin
            if (!cs_n && stb) begin
                in_frame = 1;
                k = 0;
            end
        end else if (cs_n) begin
            set[0]   = 1'b1;
            in_frame = 0;
        end else begin
            if (stb) set[5] = 1'b1;
            k++;
            if (k == 1) lo = db;
            if (k == 2) begin
                pend_cmd  = {db, lo};
                next_pend = 1;
                flen = (lo[3:0] == 2 || lo[3:0] == 3) ? 3 + int'(db[15:10]) : 2;
            end
            if (k >= 2 && k == flen) in_frame = 0;
        end
        pend  = next_pend;
        m_err = (err_clr ? 6'd0 : m_err) | set;
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        chk("valid", dut_valid, m_valid);
        chk("op", dut_op, m_op);
        chk("bank", dut_bank, m_bank);
        chk("row", dut_row, m_row);
        chk("col", dut_col, m_col);
        chk("blen", dut_blen, m_blen);
        chk("bank_open", dut_open, m_open);
        chk("busy", dut_busy, in_frame);
        chk("err", dut_err, m_err);
    end

    task automatic cyc(input logic c, input logic s, input logic [15:0] d);
        cs_n = c;
        stb  = s;
        db   = d;
        @(posedge clk);
        #2;
    endtask

    task automatic frame(input logic [15:0] w0, input logic [15:0] w1);
        cyc(1'b0, 1'b1, 16'h0000);
        cyc(1'b0, 1'b0, w0);
        cyc(1'b0, 1'b0, w1);
        if (w0[3:0] == 4'd2 || w0[3:0] == 4'd3)
            for (int i = 0; i <= int'(w1[15:10]); i++) cyc(1'b0, 1'b0, 16'h0000);
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        cyc(1'b1, 1'b0, 16'h0000);
        err_clr = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_valid", dut_valid, 0);
        chk("reset_open", dut_open, 0);
        chk("reset_err", dut_err, 0);
        chk("reset_busy", dut_busy, 0);
        rst = 1'b0;
        cyc(1'b1, 1'b0, 16'h0000);

        // ACT bank1 row 0x155
        frame(16'h5551, 16'h0000);
        cyc(1'b1, 1'b0, 16'h0000);
        chk("act_valid", dut_valid, 1);
        chk("act_op", dut_op, 4'd1);
        chk("act_bank", dut_bank, 2'd1);
        chk("act_row", dut_row, 13'h155);
        chk("act_open", dut_open, 4'b0010);
        chk("act_err", dut_err, 0);
        cyc(1'b1, 1'b0, 16'h0000);
        chk("act_valid_drop", dut_valid, 0);

        // ACT bank0, wait, WR bank0 col 0x3A blen 7
        frame(16'h0001, 16'h0000);
        repeat (4) cyc(1'b1, 1'b0, 16'h0000);
        busy_cnt = 0;
        cyc(1'b0, 1'b1, 16'h0000); busy_cnt += int'(dut_busy);
        cyc(1'b0, 1'b0, 16'h0003); busy_cnt += int'(dut_busy);
        cyc(1'b0, 1'b0, 16'h1C3A); busy_cnt += int'(dut_busy);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0, 16'h0000);
            busy_cnt += int'(dut_busy);
        end
        cyc(1'b1, 1'b0, 16'h0000);
        chk("wr_busy_cycles", busy_cnt, 10);
        chk("wr_op", dut_op, 4'd3);
        chk("wr_col", dut_col, 10'h03A);
        chk("wr_blen", dut_blen, 6'd7);
        chk("wr_err", dut_err, 0);
        chk("wr_open", dut_open, 4'b0011);

        // RD bank2 while closed
        frame(16'h0022, 16'h0005);
        cyc(1'b1, 1'b0, 16'h0000);
        chk("rd_closed_err", dut_err, 6'b000100);
        chk("rd_closed_op", dut_op, 4'd2);
        chk("rd_closed_col", dut_col, 10'd5);

        // RD right behind ACT on bank3
        clear_err();
        chk("clr_err", dut_err, 0);
        frame(16'h0031, 16'h0000);
        frame(16'h0032, 16'h0000);
        cyc(1'b1, 1'b0, 16'h0000);
        chk("trcd_err", dut_err, 6'b010000);
        chk("trcd_open", dut_open, 4'b1011);

        // cs_n high during W1
        clear_err();
        cyc(1'b0, 1'b1, 16'h0000);
        cyc(1'b0, 1'b0, 16'h0001);
        cyc(1'b1, 1'b0, 16'h0000);
        chk("abort_err", dut_err, 6'b000001);
        chk("abort_busy", dut_busy, 0);
        cyc(1'b1, 1'b0, 16'h0000);
        chk("abort_valid", dut_valid, 0);
        chk("abort_open", dut_open, 4'b1011);

        // PREA then REF
        clear_err();
        frame(16'h0005, 16'h0000);
        cyc(1'b1, 1'b0, 16'h0000);
        chk("prea_open", dut_open, 4'b0000);
        frame(16'h0006, 16'h0000);
        cyc(1'b1, 1'b0, 16'h0000);
        chk("ref_op", dut_op, 4'd6);
        chk("ref_err", dut_err, 0);

        // two ACTs with ready low
        ready = 1'b0;
        frame(16'h2AD1, 16'h0000);
        frame(16'h48E1, 16'h0001);
        cyc(1'b1, 1'b0, 16'h0000);
        chk("coll_err", dut_err, 6'b100000);
        chk("coll_valid", dut_valid, 1);
        chk("coll_bank", dut_bank, 2'd2);
        chk("coll_row", dut_row, 13'h523);
        clear_err();
        chk("coll_clr", dut_err, 0);
        chk("coll_hold", dut_valid, 1);
        ready = 1'b1;
        cyc(1'b1, 1'b0, 16'h0000);
        chk("coll_accept", dut_valid, 0);

        // reset in the middle of a frame
        cyc(1'b0, 1'b1, 16'h0000);
        cyc(1'b0, 1'b0, 16'h0011);
        rst = 1'b1;
        #1;
        chk("midrst_busy", dut_busy, 0);
        chk("midrst_open", dut_open, 0);
        cyc(1'b1, 1'b0, 16'h0000);
        rst = 1'b0;
        cyc(1'b1, 1'b0, 16'h0000);

        // randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            ready   = ($urandom_range(0, 2) != 0);
            err_clr = ($urandom_range(0, 19) == 0);
            cyc(($urandom_range(0, 11) == 0), ($urandom_range(0, 2) == 0),
                {6'($urandom_range(0, 5)), 6'($urandom), 4'($urandom_range(0, 9))});
        end
        err_clr = 1'b0;
        repeat (80) cyc(1'b1, 1'b0, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rpc_dram_cmd_receiver.md
Name: rpc_dram_cmd_receiver

Overview:
- Device-side responder for the RPC DRAM command bus driven by rpc_controller (rpc_cs_no, rpc_stb_o, phy_db_o).
- Samples command frames, assembles 32-bit commands, decodes them and tracks per-bank open/closed state.
- Flags protocol violations and presents decoded commands over a valid/ready port.
- Used in the DRAM emulation model and as a synthesizable protocol checker in FPGA bring-up.

Parameters:
- NUM_BANKS, 4, bank count; bank field is log2(NUM_BANKS) bits.
- ROW_WIDTH, 13, row address width.
- TRCD_CYCLES, 4, minimum cycles from ACT to RD/WR on the same bank.
- CNT_WIDTH, 8, width of the tRCD counters.

Ports:
- clk_i  in  1  sampling clock, command bus is SDR on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- rpc_cs_ni  in  1  chip select, active low.
- rpc_stb_i  in  1  frame start strobe.
- rpc_db_i  in  16  command/data bus.
- cmd_valid_o  out  1  decoded command available.
- cmd_ready_i  in  1  consumer accepts the command.
- cmd_op_o  out  4  opcode.
- cmd_bank_o  out  2  bank.
- cmd_row_o  out  ROW_WIDTH  row (ACT only).
- cmd_col_o  out  10  column (RD/WR).
- cmd_blen_o  out  6  burst beats minus 1 (RD/WR).
- bank_open_o  out  NUM_BANKS  per-bank open flag.
- busy_o  out  1  frame or data phase in progress.
- err_o  out  6  sticky error flags: [0] abort, [1] illegal op, [2] closed-bank access, [3] ACT to open bank, [4] tRCD violation, [5] overflow/collision.
- err_clr_i  in  1  clears err_o.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all banks closed, counters 0.
- Command word: cmd[3:0] op, cmd[5:4] bank, cmd[18:6] row, cmd[25:16] col, cmd[31:26] blen.
  - Row and col overlap; each op uses only its own fields.
- Opcodes: 1 ACT, 2 RD, 3 WR, 4 PRE, 5 PREA, 6 REF, 7 ZQC, 8 MRS. Any other value is illegal.
- FSM states IDLE, W0, W1, DATA.
  - IDLE: on cs_n=0 and stb=1, go to W0.
  - W0: capture db into cmd[15:0], go to W1.
  - W1: capture db into cmd[31:16] and decode in the same cycle.
    - Decoded output registers update at the next edge, so cmd_valid_o rises 1 cycle after the W1 capture edge: 3 cycles after the stb-sampled edge.
    - RD/WR go to DATA with beat counter = blen. All other ops go to IDLE.
  - DATA: counter decrements each cycle; at 0 go to IDLE. Duration is blen+1 cycles; data content is ignored.
- cs_n=1 sampled in W0/W1/DATA: abort, set err[0], go to IDLE, no command emitted, bank state unchanged.
- stb=1 in W0/W1/DATA with cs_n low: set err[5], strobe ignored, frame continues.
- busy_o=1 in W0/W1/DATA.
- Output handshake:
  - Valid holds with stable fields until cmd_valid_o & cmd_ready_i.
  - If a new command decodes while the previous one is not accepted: set err[5], replace the pending command with the new one, and keep valid asserted.
  - Accept and new decode in the same cycle: new command loaded, valid stays 1, no error.
- Bank tracking is updated at decode, regardless of handshake:
  - ACT to a closed bank: open it, load its tRCD counter with TRCD_CYCLES-1.
  - ACT to an open bank: err[3]; bank stays open with the original row; counter reloads.
  - PRE: close the bank; no error if already closed.
  - PREA: close all banks.
  - REF/ZQC with any bank open: err[2].
  - RD/WR to a closed bank: err[2].
  - RD/WR with the bank counter not 0: err[4].
  - Counters decrement by 1 per cycle, saturating at 0.
- Illegal opcode: err[1]; the command is still emitted with raw op, and there is no bank effect.
- The command is emitted regardless of error flags, except on abort.
- err_clr_i clears err_o; an error raised in the same cycle wins (stays set).
- Reset mid-frame: immediate return to reset state; the partial frame is discarded.

Test Plan:
- ACT bank1 row 0x155, ready=1:
  - db words 0x5551 then 0x0000 → cmd_valid_o for 1 cycle 3 cycles after stb with op=1, bank=1, row=0x155.
  - bank_open_o=4'b0010, err_o=0.
- ACT bank0, wait 4 cycles, WR bank0 col 0x3A blen 7:
  - No error; busy_o high for 2+8 cycles after stb.
- RD bank2 while closed → err[2] set, command still emitted.
- RD 2 cycles after ACT on the same bank → err[4].
- cs_n rises during W1 → err[0], no cmd_valid_o, FSM in IDLE next cycle.
- Two ACT frames with ready=0:
  - err[5] set; second command held on outputs.
  - err_clr_i pulse → err_o=0.
- PREA after opening banks 0 and 3 → bank_open_o=0.
- REF then issued → no error.
